// File: rtl/pubkey_gen_pkg.sv
// Shared definitions for the public-key generator and the verifier-side hash.
// Provides the public-key type tag, the Pearson table width and FSM states.
package keypack_defs;

  // Type code the verifier expects in public_key[11:8].
  localparam logic [3:0] KEY_TAG    = 4'h2;

  // 256 entries of 8 bits each.
  localparam int         TABLE_BITS = 2048;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HASH = 1'b1
  } state_e;

endpackage : keypack_defs

// File: rtl/pubkey_gen_pearson_step.sv
// One Pearson hash round: h_next = T[h ^ byte].
// Purely combinational, so the verifier-side hash can reuse it.
module pearson_step
  import keypack_defs::*;
(
  input  logic [7:0]            h_i,
  input  logic [7:0]            byte_i,
  input  logic [TABLE_BITS-1:0] table_i,
  output logic [7:0]            h_next_o
);

  logic [7:0] idx;

  // Look up the table entry selected by the XOR of hash and key byte.
  always_comb begin
    // NOTE: assign every always_comb output on every path so no latch is inferred.
    idx      = h_i ^ byte_i;
    h_next_o = table_i[{idx, 3'b000} +: 8];
  end

endmodule : pearson_step

// File: rtl/pubkey_gen.sv
// Public-key generator: Pearson-hashes a latched private key one byte per
// clock and presents {KEY_TAG, hash} with a one-cycle done pulse.
// Optional build macro PUBKEY_GEN_BUSY_ERR_EN adds a start_err output that
// flags start requests arriving while a hash is in flight.
module pubkey_gen
  import keypack_defs::*;
#(
  parameter int         KEY_BYTES = 1,
  parameter logic [7:0] SEED      = 8'h00
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] private_key,
  input  logic [TABLE_BITS-1:0]  random_table,
  output logic                   busy,
  output logic                   done,
  output logic                   key_valid,
  output logic [11:0]            public_key
`ifdef PUBKEY_GEN_BUSY_ERR_EN
  ,
  output logic                   start_err
`endif
);

  localparam int              CNT_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_BYTES - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [7:0]             h_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             cur_byte;
  logic [7:0]             h_d;

  // Byte cnt_q of the latched key, byte 0 in the low bits.
  always_comb begin
    cur_byte = 8'(key_q >> {cnt_q, 3'b000});
  end

  pearson_step u_step (
    .h_i      (h_q),
    .byte_i   (cur_byte),
    .table_i  (random_table),
    .h_next_o (h_d)
  );

  // Control FSM with all outputs registered; reset is synchronous.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      // NOTE: state uses <= so every register samples pre-edge values.
      state_q    <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      key_valid  <= 1'b0;
      public_key <= 12'h000;
      cnt_q      <= '0;
      h_q        <= SEED;
      // NOTE: key_q is a plain data register; clearing it keeps reset state deterministic.
      key_q      <= '0;
`ifdef PUBKEY_GEN_BUSY_ERR_EN
      start_err  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef PUBKEY_GEN_BUSY_ERR_EN
      start_err <= start && (state_q == ST_HASH);
`endif
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            key_q     <= private_key;
            h_q       <= SEED;
            cnt_q     <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b1;
            state_q   <= ST_HASH;
          end
        end
        ST_HASH: begin
          h_q <= h_d;
          if (cnt_q == LAST_CNT) begin
            public_key <= {KEY_TAG, h_d};
            done       <= 1'b1;
            key_valid  <= 1'b1;
            busy       <= 1'b0;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= CNT_W'(cnt_q + 1'b1);
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : pubkey_gen

// File: tb/tb_pubkey_gen.sv
// Testbench for pubkey_gen: two instances (KEY_BYTES=1 and KEY_BYTES=2)
// share clock, reset and table. A reference model pushes expected results
// into per-instance queues when a start is accepted; a monitor pops and
// compares whenever done is seen.
module tb_pubkey_gen;
  import keypack_defs::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                  resetn;
  logic                  start0, start1;
  logic [7:0]            key0;
  logic [15:0]           key1;
  logic [TABLE_BITS-1:0] random_table;
  logic [7:0]            tbl [256];

  logic        busy0, done0, kv0;
  logic        busy1, done1, kv1;
  logic [11:0] pk0, pk1;
`ifdef PUBKEY_GEN_BUSY_ERR_EN
  logic        err0, err1;
`endif

  pubkey_gen #(.KEY_BYTES(1), .SEED(8'h00)) u_dut0 (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start0),
    .private_key  (key0),
    .random_table (random_table),
    .busy         (busy0),
    .done         (done0),
    .key_valid    (kv0),
    .public_key   (pk0)
`ifdef PUBKEY_GEN_BUSY_ERR_EN
    ,
    .start_err    (err0)
`endif
  );

  pubkey_gen #(.KEY_BYTES(2), .SEED(8'h00)) u_dut1 (
    .clock        (clock),
    .resetn       (resetn),
    .start        (start1),
    .private_key  (key1),
    .random_table (random_table),
    .busy         (busy1),
    .done         (done1),
    .key_valid    (kv1),
    .public_key   (pk1)
`ifdef PUBKEY_GEN_BUSY_ERR_EN
    ,
    .start_err    (err1)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  // Reference model state, per instance.
  int          rem   [2];
  logic [11:0] pend  [2];
  logic        due   [2];
  logic [11:0] m_pk  [2];
  logic        m_kv  [2];
  logic        m_err [2];
  logic [11:0] q0 [$];
  logic [11:0] q1 [$];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pearson hash straight from the definition: h0 = 0, h = T[h ^ byte_k].
  function automatic logic [11:0] ref_key(input int kb, input logic [15:0] key);
    logic [7:0] h;
    h = 8'h00;
    for (int k = 0; k < kb; k++) h = tbl[h ^ key[8*k +: 8]];
    return {4'h2, h};
  endfunction

  task automatic set_table(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0:       tbl[i] = 8'(i);
        1:       tbl[i] = 8'(i + 1);
        default: tbl[i] = 8'($urandom_range(0, 255));
      endcase
      random_table[8*i +: 8] = tbl[i];
    end
  endtask

  // Model: decides acceptance from its own busy counter and records results.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      logic        st;
      logic [15:0] k;
      logic [11:0] e;
      st       = (i == 0) ? start0 : start1;
      k        = (i == 0) ? {8'h00, key0} : key1;
      due[i]   = 1'b0;
      m_err[i] = 1'b0;
      if (!resetn) begin
        if (rem[i] != 0) begin
          if (i == 0) void'(q0.pop_back());
          else        void'(q1.pop_back());
        end
        rem[i]  = 0;
        m_pk[i] = 12'h000;
        m_kv[i] = 1'b0;
      end else if (rem[i] == 0) begin
        if (st) begin
          e = ref_key(i + 1, k);
          if (i == 0) q0.push_back(e);
          else        q1.push_back(e);
          pend[i] = e;
          rem[i]  = i + 1;
          m_kv[i] = 1'b0;
        end
      end else begin
        m_err[i] = st;
        rem[i]   = rem[i] - 1;
        if (rem[i] == 0) begin
          due[i]  = 1'b1;
          m_pk[i] = pend[i];
          m_kv[i] = 1'b1;
        end
      end
    end
  end

  task automatic mon_inst(input int i, input logic b, input logic d, input logic kv,
                          input logic [11:0] pk);
    logic [11:0] e;
    if (d) begin
      if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done[%0d]: got done=1 expected no pending result at %0t", i, $time);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("result[%0d]", i), pk, e);
      end
    end else if (due[i]) begin
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    check($sformatf("done[%0d]", i), {11'b0, d}, {11'b0, due[i]});
    check($sformatf("busy[%0d]", i), {11'b0, b}, {11'b0, rem[i] != 0});
    check($sformatf("key_valid[%0d]", i), {11'b0, kv}, {11'b0, m_kv[i]});
    check($sformatf("public_key[%0d]", i), pk, m_pk[i]);
  endtask

  // Monitor: samples outputs on the falling edge.
  always @(negedge clock) begin
    if (mon_en) begin
      mon_inst(0, busy0, done0, kv0, pk0);
      mon_inst(1, busy1, done1, kv1, pk1);
`ifdef PUBKEY_GEN_BUSY_ERR_EN
      check("start_err[0]", {11'b0, err0}, {11'b0, m_err[0]});
      check("start_err[1]", {11'b0, err1}, {11'b0, m_err[1]});
`endif
    end
  end

  task automatic pulse(input int i, input logic [15:0] key);
    @(negedge clock);
    if (i == 0) begin key0 = key[7:0]; start0 = 1'b1; end
    else        begin key1 = key;      start1 = 1'b1; end
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Counts falling edges until done; a missing done is a miscompare.
  task automatic wait_done(input int i, output int n);
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if ((i == 0) ? done0 : done1) begin
        n = c;
        break;
      end
    end
    if (n == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout[%0d]: got no done expected done within 20 cycles", i);
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (rem[0] == 0 && rem[1] == 0) break;
    end
    @(negedge clock);
  endtask

  initial begin
    int          n;
    logic [15:0] k;
    rem[0] = 0; rem[1] = 0;
    resetn = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    key0 = 8'h00; key1 = 16'h0000;
    set_table(0);
    repeat (3) @(negedge clock);
    mon_en = 1'b1;
    check("reset_pk", pk1, 12'h000);
    resetn = 1'b1;

    // Single byte, identity table.
    pulse(0, 16'h00A5);
    wait_done(0, n);
    check("t1_latency", 12'(n), 12'd1);
    check("t1_pk", pk0, 12'h2A5);
    check("t1_kv", {11'b0, kv0}, 12'h001);

    // Two bytes, identity table: 3C ^ 0F.
    pulse(1, 16'h0F3C);
    check("t2_busy", {11'b0, busy1}, 12'h001);
    wait_done(1, n);
    check("t2_latency", 12'(n), 12'd2);
    check("t2_pk", pk1, 12'h233);

    // Increment table wraps 0xFF to 0x00.
    set_table(1);
    pulse(0, 16'h00FF);
    wait_done(0, n);
    check("t3_wrap", pk0, 12'h200);
    pulse(0, 16'h0000);
    wait_done(0, n);
    check("t3_next", pk0, 12'h201);

    // Start held for four cycles: extra starts dropped, back-to-back accepted.
    @(negedge clock);
    key1   = 16'($urandom);
    start1 = 1'b1;
    repeat (4) @(negedge clock);
    start1 = 1'b0;
    wait_idle();

    // Reset during the first hash cycle aborts the run and clears outputs.
    set_table(0);
    @(negedge clock);
    key1   = 16'h0F3C;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check("t5_pk_cleared", pk1, 12'h000);
    check("t5_busy", {11'b0, busy1}, 12'h000);
    check("t5_done", {11'b0, done1}, 12'h000);
    check("t5_kv", {11'b0, kv1}, 12'h000);
    pulse(1, 16'h0F3C);
    wait_done(1, n);
    check("t5_rerun", pk1, 12'h233);

    // Key changes right after start; result follows the latched key.
    set_table(2);
    k = 16'($urandom);
    @(negedge clock);
    key1   = k;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    key1   = ~k;
    wait_done(1, n);
    check("t6_latched", pk1, ref_key(2, k));

    // Random traffic with occasional resets; table changes only while idle.
    for (int blk = 0; blk < 8; blk++) begin
      set_table(2);
      for (int c = 0; c < 40; c++) begin
        @(negedge clock);
        start0 = 1'($urandom_range(0, 1));
        start1 = 1'($urandom_range(0, 1));
        key0   = 8'($urandom);
        key1   = 16'($urandom);
        resetn = ($urandom_range(0, 63) != 0);
      end
      @(negedge clock);
      start0 = 1'b0;
      start1 = 1'b0;
      resetn = 1'b1;
      wait_idle();
    end

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pubkey_gen
